wide_frame_rx: RTL and testbench
================================

// Module: wide_frame_rx
// PURPOSE
//  Consumes the 64-bit AXIS word stream produced by the UART word-assembly stage
//  (its m_axis port) and recovers framed packets from it.
//  Frame = header word, LEN payload words, trailer word carrying an XOR checksum.
//  Store-and-forward: a frame is buffered and released downstream only if its
//  checksum matches. Bad frames are dropped and counted.
// PARAMETERS
//  MAGIC    16'hA55A  required value of header[63:48]
//  MAX_LEN  16        buffer depth in 64-bit words; largest legal LEN
//  CNT_W    16        width of the saturating ok/error counters
// PORTS
//  clk            in   1      single clock
//  rst            in   1      reset; asynchronous, active-low
//  s_axis_tdata   in   64     words from the UART stage
//  s_axis_tvalid  in   1
//  s_axis_tready  out  1
//  m_axis_tdata   out  64     verified payload words
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1      marks the last payload word of a frame
//  m_axis_tuser   out  8      frame type (header[47:40]); held for the whole frame
//  frame_ok       out  1      1-cycle pulse: frame accepted
//  frame_err      out  1      1-cycle pulse: frame rejected
//  err_code       out  2      valid with frame_err: 1 = bad LEN, 2 = checksum mismatch
//  ok_count       out  CNT_W  accepted frames; saturates at all-ones
//  err_count      out  CNT_W  rejected frames; saturates at all-ones
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low.
//  - While rst=0: state=HUNT and all outputs are 0. This includes s_axis_tready,
//    the pulses, both counters and the buffer pointers. Reset mid-frame discards
//    the frame; m_axis_tvalid drops immediately.
//  - Header word fields: [63:48] magic, [47:40] type, [39:8] reserved (ignored),
//    [7:0] LEN.
//  - Checksum is the 64-bit XOR of the header and all payload words. The trailer
//    word must equal it.
//  - s_axis_tready = 1 in HUNT, PAYLOAD and TRAILER; 0 in DRAIN.
//  - A word is accepted when s_axis_tvalid and s_axis_tready are both 1.
//  - HUNT: on each accepted word:
//      magic match, 1<=LEN<=MAX_LEN: latch LEN and type, csum=word, wr_ptr=0,
//        go to PAYLOAD.
//      magic match, LEN=0 or LEN>MAX_LEN: frame_err pulse with err_code=1,
//        err_count+1, stay in HUNT.
//      no magic match: word discarded silently, stay in HUNT (resync).
//  - PAYLOAD: each accepted word is written to buf[wr_ptr], then csum^=word and
//    wr_ptr+1. When the word at wr_ptr==LEN-1 is accepted, go to TRAILER.
//  - TRAILER: compare the accepted word with csum.
//      equal: frame_ok pulse, ok_count+1, rd_ptr=0, go to DRAIN.
//      not equal: frame_err pulse with err_code=2, err_count+1, buffer
//        discarded, go to HUNT.
//  - DRAIN outputs:
//      m_axis_tvalid = 1.
//      m_axis_tdata = buf[rd_ptr].
//      m_axis_tlast = (rd_ptr==LEN-1).
//  - DRAIN handshake: on each handshake rd_ptr+1. After the tlast handshake, go
//    to HUNT. No new input is taken until the next cycle.
//  - Latency: the first payload word is valid on m_axis the cycle after the
//    trailer handshake.
//  - frame_ok and frame_err are registered. They assert in that same cycle.
//  - AXIS rule: tdata, tlast and tuser stay stable while tvalid=1 and tready=0.
//  - Pointers are log2(MAX_LEN) bits. LEN is checked before use, so wr_ptr never
//    wraps past MAX_LEN-1.
//  - err_code holds its value until the next frame_err.
//  - Counters saturate; they do not wrap.
// TESTING
//  T1 good frame: header 64'hA55A_0300_0000_0002, payload 64'h1111_1111_1111_1111
//     and 64'h2222_2222_2222_2222, trailer 64'h9669_3033_3333_3331.
//     -> frame_ok pulse; ok_count=1; 2 m_axis words in order; tlast on the 2nd;
//     tuser=8'h03.
//  T2 T1 frame with trailer 64'h0 -> frame_err, err_code=2, err_count=1,
//     no m_axis_tvalid. A following T1 frame is delivered intact.
//  T3 header LEN=0, then header LEN=17 -> two frame_err pulses with err_code=1,
//     err_count=2, state stays HUNT.
//  T4 three non-magic words (e.g. 64'hDEAD_BEEF_0000_0001) then a T1 frame
//     -> garbage ignored with no pulses; frame delivered.
//  T5 LEN=16 frame with m_axis_tready held low 5 cycles mid-drain
//     -> data/tlast/tuser stable; s_axis_tready=0 through DRAIN; 16 words exact.
//  T6 rst asserted during PAYLOAD -> all outputs 0 asynchronously; counters 0;
//     after release a T1 frame gives ok_count=1.

Source files
------------

// File: rtl/wide_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : wide_frame_rx_if
//  Description : AXI-Stream style word channel used on both sides of the
//                wide frame receiver (64-bit data, 8-bit user sideband).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wide_frame_rx_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    // The receive side only consumes data/valid; upstream framing is in-band
    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/wide_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : wide_frame_rx
//  Description : Store-and-forward frame receiver. Buffers header/payload/
//                trailer frames, releases payload only on checksum match.
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_frame_rx #(
    parameter logic [15:0] MAGIC   = 16'hA55A,
    parameter int          MAX_LEN = 16,
    parameter int          CNT_W   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    wide_frame_rx_if.slave        s_axis,
    wide_frame_rx_if.master       m_axis,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code,
    output logic [CNT_W-1:0]      ok_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam int         PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [63:0]        r_buf [MAX_LEN];
    logic [63:0]        r_csum;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_last;
    logic [7:0]         r_type;
    logic               r_frame_ok;
    logic               r_frame_err;
    logic [1:0]         r_err_code;
    logic [CNT_W-1:0]   r_ok_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_s_ready;
    logic               w_s_fire;
    logic               w_m_fire;
    logic [7:0]         w_len;
    logic               w_magic;
    logic               w_len_ok;
    logic               w_hdr_ok;
    logic               w_len_err;
    logic               w_csum_ok;
    logic               w_csum_err;
    logic               w_rd_last;

    // tready is forced low while reset is held, not just while in DRAIN
    assign w_s_ready     = rst && (r_state != ST_DRAIN);
    assign w_s_fire      = s_axis.tvalid && w_s_ready;
    assign s_axis.tready = w_s_ready;

    assign w_len    = s_axis.tdata[7:0];
    assign w_magic  = (s_axis.tdata[63:48] == MAGIC);
    assign w_len_ok = (w_len != 8'd0) && (w_len <= c_max_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_hdr_ok      = 1'b0;
        w_len_err     = 1'b0;
        w_csum_ok     = 1'b0;
        w_csum_err    = 1'b0;
        w_rd_last     = 1'b0;
        w_m_fire      = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = 64'd0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 8'd0;
        case (r_state)
            ST_HUNT: begin
                if (w_s_fire && w_magic) begin
                    if (w_len_ok) begin
                        w_hdr_ok = 1'b1;
                        w_next   = ST_PAYLOAD;
                    end else begin
                        w_len_err = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_s_fire && (r_wr_ptr == r_last)) begin
                    w_next = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                if (w_s_fire) begin
                    if (s_axis.tdata == r_csum) begin
                        w_csum_ok = 1'b1;
                        w_next    = ST_DRAIN;
                    end else begin
                        w_csum_err = 1'b1;
                        w_next     = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                w_rd_last     = (r_rd_ptr == r_last);
                w_m_fire      = m_axis.tready;
                m_axis.tvalid = 1'b1;
                m_axis.tdata  = r_buf[r_rd_ptr];
                m_axis.tlast  = w_rd_last;
                m_axis.tuser  = r_type;
                if (m_axis.tready && w_rd_last) begin
                    w_next = ST_HUNT;
                end
            end
            default: w_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum      <= 64'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last      <= '0;
            r_type      <= 8'd0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
            r_ok_cnt    <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_frame_ok  <= w_csum_ok;
            r_frame_err <= w_len_err || w_csum_err;
            if (w_hdr_ok) begin
                r_csum   <= s_axis.tdata;
                r_wr_ptr <= '0;
                r_last   <= PTR_W'(w_len - 8'd1);
                r_type   <= s_axis.tdata[47:40];
            end
            if ((r_state == ST_PAYLOAD) && w_s_fire) begin
                r_csum   <= r_csum ^ s_axis.tdata;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_csum_ok) begin
                r_rd_ptr <= '0;
                if (r_ok_cnt != '1) begin
                    r_ok_cnt <= r_ok_cnt + CNT_W'(1);
                end
            end
            if (w_m_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_len_err || w_csum_err) begin
                r_err_code <= w_len_err ? 2'd1 : 2'd2;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Payload storage is plain RAM; its contents are never visible outside DRAIN
    always_ff @(posedge clk) begin
        if ((r_state == ST_PAYLOAD) && w_s_fire) begin
            r_buf[r_wr_ptr] <= s_axis.tdata;
        end
    end

    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;
    assign err_code  = r_err_code;
    assign ok_count  = r_ok_cnt;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wide_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_frame_rx
//  Description : Directed + randomized bench for wide_frame_rx against a
//                frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] ok_count;
    logic [15:0] err_count;

    int          n_pass  = 0;
    int          n_total = 0;

    logic [15:0] exp_ok   = 16'd0;
    logic [15:0] exp_err  = 16'd0;
    logic [1:0]  exp_code = 2'd0;

    always #5 clk = ~clk;

    wide_frame_rx_if #(.DATA_W(64), .USER_W(8)) s_if ();
    wide_frame_rx_if #(.DATA_W(64), .USER_W(8)) m_if ();

    wide_frame_rx #(.MAGIC(16'hA55A), .MAX_LEN(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .ok_count  (ok_count),
        .err_count (err_count)
    );

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_word(input logic [63:0] w);
        if ($urandom_range(0, 3) == 0) begin
            s_if.tvalid = 1'b0;
            s_if.tdata  = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        s_if.tdata  = w;
        s_if.tvalid = 1'b1;
        for (int k = 0; k < 50 && !s_if.tready; k++) begin
            @(posedge clk); #1;
        end
        check("s_tready_wait", 64'(s_if.tready), 64'd1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = {$urandom, $urandom};
    endtask

    // mode 0: always ready, 1: random ready, 2: five stall cycles mid-drain
    task automatic collect(input logic [63:0] exp_q[$], input logic [7:0] typ, input int mode);
        int          idx  = 0;
        int          cyc  = 0;
        bit          held = 0;
        logic [63:0] hd   = 64'd0;
        logic        hl   = 1'b0;
        logic [7:0]  hu   = 8'd0;
        while (idx < exp_q.size() && cyc < 400) begin
            case (mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = !(cyc >= 4 && cyc <= 8);
            endcase
            check("drain_s_tready", 64'(s_if.tready), 64'd0);
            check("drain_m_tvalid", 64'(m_if.tvalid), 64'd1);
            if (held) begin
                check("stall_tdata", m_if.tdata, hd);
                check("stall_tlast", 64'(m_if.tlast), 64'(hl));
                check("stall_tuser", 64'(m_if.tuser), 64'(hu));
            end
            if (m_if.tvalid && m_if.tready) begin
                check("drain_tdata", m_if.tdata, exp_q[idx]);
                check("drain_tlast", 64'(m_if.tlast), 64'(idx == exp_q.size() - 1));
                check("drain_tuser", 64'(m_if.tuser), 64'(typ));
                idx++;
                held = 0;
            end else begin
                hd   = m_if.tdata;
                hl   = m_if.tlast;
                hu   = m_if.tuser;
                held = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check("frame_ok_width", 64'(frame_ok), 64'd0);
        end
        m_if.tready = 1'b0;
        check("drain_count", 64'(idx), 64'(exp_q.size()));
        check("post_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("post_s_tready", 64'(s_if.tready), 64'd1);
    endtask

    // Reference model: classifies the frame from the header/trailer rules and
    // updates the expected counters, then checks the DUT's reaction.
    task automatic run_frame(input logic [63:0] hdr, input logic [63:0] pl[$],
                             input logic [63:0] trl, input int mode);
        logic [7:0]  len   = hdr[7:0];
        bit          magic = (hdr[63:48] == 16'hA55A);
        logic [63:0] x     = hdr;
        send_word(hdr);
        if (!magic) begin
            check("garbage_ok", 64'(frame_ok), 64'd0);
            check("garbage_err", 64'(frame_err), 64'd0);
            check("garbage_hunt", 64'(s_if.tready), 64'd1);
        end else if (len == 8'd0 || len > 8'd16) begin
            exp_err  = sat_inc(exp_err);
            exp_code = 2'd1;
            check("len_err_pulse", 64'(frame_err), 64'd1);
            check("len_err_code", 64'(err_code), 64'(exp_code));
            check("len_err_count", 64'(err_count), 64'(exp_err));
            check("len_err_hunt", 64'(s_if.tready), 64'd1);
        end else begin
            foreach (pl[i]) begin
                send_word(pl[i]);
                x = x ^ pl[i];
            end
            send_word(trl);
            if (trl == x) begin
                exp_ok = sat_inc(exp_ok);
                check("ok_pulse", 64'(frame_ok), 64'd1);
                check("ok_no_err", 64'(frame_err), 64'd0);
                check("ok_count", 64'(ok_count), 64'(exp_ok));
                check("ok_err_count", 64'(err_count), 64'(exp_err));
                check("ok_err_code_hold", 64'(err_code), 64'(exp_code));
                collect(pl, hdr[47:40], mode);
            end else begin
                exp_err  = sat_inc(exp_err);
                exp_code = 2'd2;
                check("csum_err_pulse", 64'(frame_err), 64'd1);
                check("csum_no_ok", 64'(frame_ok), 64'd0);
                check("csum_err_code", 64'(err_code), 64'(exp_code));
                check("csum_err_count", 64'(err_count), 64'(exp_err));
                check("csum_no_tvalid", 64'(m_if.tvalid), 64'd0);
            end
        end
    endtask

    task automatic make_good(input int len, output logic [63:0] hdr,
                             output logic [63:0] pl[$], output logic [63:0] trl);
        logic [63:0] w;
        hdr = {16'hA55A, 8'($urandom), 32'($urandom), 8'(len)};
        trl = hdr;
        pl  = {};
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            pl.push_back(w);
            trl = trl ^ w;
        end
    endtask

    initial begin
        logic [63:0] t1_hdr;
        logic [63:0] t1_pl[$];
        logic [63:0] t1_trl;
        logic [63:0] hdr;
        logic [63:0] pl[$];
        logic [63:0] trl;
        logic [63:0] empty_q[$];
        logic [63:0] g;
        int          kind;

        t1_hdr  = 64'hA55A_0300_0000_0002;
        t1_pl   = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        t1_trl  = 64'h9669_3033_3333_3331;
        empty_q = {};

        rst         = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 64'd0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 8'd0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata", m_if.tdata, 64'd0);
        check("rst_frame_ok", 64'(frame_ok), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_ok_count", 64'(ok_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("hunt_s_tready", 64'(s_if.tready), 64'd1);

        // T1 good frame
        run_frame(t1_hdr, t1_pl, t1_trl, 0);
        check("t1_ok_count", 64'(ok_count), 64'd1);

        // T2 bad trailer, then intact frame
        run_frame(t1_hdr, t1_pl, 64'd0, 0);
        check("t2_err_count", 64'(err_count), 64'd1);
        run_frame(t1_hdr, t1_pl, t1_trl, 1);

        // T3 LEN=0 and LEN=17
        run_frame(64'hA55A_0100_0000_0000, empty_q, 64'd0, 0);
        run_frame(64'hA55A_0100_0000_0011, empty_q, 64'd0, 0);
        check("t3_err_count", 64'(err_count), 64'd3);

        // T4 garbage then frame
        for (int i = 0; i < 3; i++) run_frame(64'hDEAD_BEEF_0000_0001, empty_q, 64'd0, 0);
        run_frame(t1_hdr, t1_pl, t1_trl, 0);

        // T5 LEN=16 with stalled drain
        make_good(16, hdr, pl, trl);
        run_frame(hdr, pl, trl, 2);

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 1) begin
                g = {$urandom, $urandom};
                if (g[63:48] == 16'hA55A) g[48] = ~g[48];
                run_frame(g, empty_q, 64'd0, 0);
            end else if (kind == 2) begin
                g        = {16'hA55A, 8'($urandom), 32'($urandom), 8'd0};
                g[7:0]   = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255));
                run_frame(g, empty_q, 64'd0, 0);
            end else begin
                make_good(int'($urandom_range(1, 16)), hdr, pl, trl);
                if (kind == 3) trl = trl ^ (64'd1 << $urandom_range(0, 63));
                run_frame(hdr, pl, trl, int'($urandom_range(0, 1)));
            end
        end

        // T6 reset during payload
        send_word(t1_hdr);
        send_word(t1_pl[0]);
        #2 rst = 1'b0;
        #1;
        check("t6_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("t6_s_tready", 64'(s_if.tready), 64'd0);
        check("t6_frame_ok", 64'(frame_ok), 64'd0);
        check("t6_frame_err", 64'(frame_err), 64'd0);
        check("t6_err_code", 64'(err_code), 64'd0);
        check("t6_ok_count", 64'(ok_count), 64'd0);
        check("t6_err_count", 64'(err_count), 64'd0);
        exp_ok   = 16'd0;
        exp_err  = 16'd0;
        exp_code = 2'd0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        run_frame(t1_hdr, t1_pl, t1_trl, 0);
        check("t6_ok_after", 64'(ok_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
